// File: rtl/gpr_wb_arbiter.sv
// GPR write-port arbiter: round-robin between EXU and LSU writeback, plus a
// per-register pending-write scoreboard used for RAW hazard detection.
module gpr_wb_arbiter #(
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      wbarb_clk,
  input  logic                      wbarb_rst,
  input  logic                      iss_valid,
  input  logic [GPR_ADDR_WIDTH-1:0] iss_rd,
  output logic                      iss_ready,
  input  logic [GPR_ADDR_WIDTH-1:0] chk_raddr1,
  input  logic [GPR_ADDR_WIDTH-1:0] chk_raddr2,
  output logic                      chk_busy1,
  output logic                      chk_busy2,
  input  logic                      exu_valid,
  input  logic [GPR_ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0]     exu_wdata,
  output logic                      exu_ready,
  input  logic                      lsu_valid,
  input  logic [GPR_ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0]     lsu_wdata,
  output logic                      lsu_ready,
  output logic                      gpr_wen,
  output logic [GPR_ADDR_WIDTH-1:0] gpr_waddr,
  output logic [DATA_WIDTH-1:0]     gpr_wdata,
  output logic [GPR_ADDR_WIDTH:0]   pend_cnt,
  output logic                      wb_err
);

  localparam int NREG = 1 << GPR_ADDR_WIDTH;
  localparam logic [GPR_ADDR_WIDTH:0] CNT_ONE = {{GPR_ADDR_WIDTH{1'b0}}, 1'b1};

  logic [NREG-1:0]           busy_q, busy_d;
  logic [GPR_ADDR_WIDTH:0]   pend_q, pend_d;
  logic                      err_q, err_d;
  logic                      rr_q, rr_d;
  logic                      wen_q, wen_d;
  logic [GPR_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;

  logic                      exu_gnt, lsu_gnt, gnt;
  logic [GPR_ADDR_WIDTH-1:0] gnt_rd;
  logic [DATA_WIDTH-1:0]     gnt_data;
  logic                      sb_set, sb_clr;

  // rr_q == 0 favours EXU, rr_q == 1 favours LSU.
  always_comb begin
    exu_gnt  = !wbarb_rst && exu_valid && (!lsu_valid || !rr_q);
    lsu_gnt  = !wbarb_rst && lsu_valid && (!exu_valid || rr_q);
    gnt      = exu_gnt || lsu_gnt;
    gnt_rd   = lsu_gnt ? lsu_rd : exu_rd;
    gnt_data = lsu_gnt ? lsu_wdata : exu_wdata;
  end

  assign exu_ready = exu_gnt;
  assign lsu_ready = lsu_gnt;
  assign iss_ready = !wbarb_rst && ((iss_rd == '0) || !busy_q[iss_rd]);
  assign chk_busy1 = (chk_raddr1 != '0) && busy_q[chk_raddr1];
  assign chk_busy2 = (chk_raddr2 != '0) && busy_q[chk_raddr2];

  always_comb begin
    sb_set = iss_valid && iss_ready && (iss_rd != '0);
    // Only a write that actually retires a pending entry decrements the count;
    // an erroneous write to a non-busy register leaves it untouched.
    sb_clr = wen_q && busy_q[waddr_q];

    busy_d = busy_q;
    if (wen_q) busy_d[waddr_q] = 1'b0;
    if (sb_set) busy_d[iss_rd] = 1'b1;

    pend_d = pend_q;
    if (sb_set && !sb_clr)      pend_d = pend_q + CNT_ONE;
    else if (!sb_set && sb_clr) pend_d = pend_q - CNT_ONE;

    err_d   = err_q || (gnt && (gnt_rd != '0) && !busy_q[gnt_rd]);
    wen_d   = gnt && (gnt_rd != '0);
    waddr_d = wen_d ? gnt_rd : waddr_q;
    wdata_d = wen_d ? gnt_data : wdata_q;

    rr_d = rr_q;
    if (exu_gnt)      rr_d = 1'b1;
    else if (lsu_gnt) rr_d = 1'b0;
  end

  always_ff @(posedge wbarb_clk) begin
    if (wbarb_rst) begin
      busy_q  <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
      rr_q    <= 1'b0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      rr_q    <= rr_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign gpr_wen   = wen_q;
  assign gpr_waddr = waddr_q;
  assign gpr_wdata = wdata_q;
  assign pend_cnt  = pend_q;
  assign wb_err    = err_q;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Bench for gpr_wb_arbiter: scenario tasks plus a write-port scoreboard.
module tb_gpr_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic [4:0]  chk_raddr1, chk_raddr2;
  logic        chk_busy1, chk_busy2;
  logic        exu_valid;
  logic [4:0]  exu_rd;
  logic [31:0] exu_wdata;
  logic        exu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_wdata;
  logic        lsu_ready;
  logic        gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic [5:0]  pend_cnt;
  logic        wb_err;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  pass_cnt = 0;
  int  chk_cnt  = 0;

  always #5 clk = ~clk;

  gpr_wb_arbiter #(.GPR_ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .wbarb_clk(clk), .wbarb_rst(rst),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .chk_raddr1(chk_raddr1), .chk_raddr2(chk_raddr2),
    .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
    .exu_valid(exu_valid), .exu_rd(exu_rd), .exu_wdata(exu_wdata), .exu_ready(exu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_wdata(lsu_wdata), .lsu_ready(lsu_ready),
    .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .pend_cnt(pend_cnt), .wb_err(wb_err)
  );

  // Every emitted write must match the oldest expected write.
  always @(negedge clk) begin
    if (gpr_wen === 1'b1) begin
      wr_t e;
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL wr_unexpected got addr=%0d data=%h, none expected", gpr_waddr, gpr_wdata);
      end else begin
        e = exp_q.pop_front();
        if (gpr_waddr !== e.addr || gpr_wdata !== e.data)
          $display("FAIL wr_data got addr=%0d data=%h, want addr=%0d data=%h",
                   gpr_waddr, gpr_wdata, e.addr, e.data);
        else pass_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    iss_valid = 0; iss_rd = 0; chk_raddr1 = 0; chk_raddr2 = 0;
    exu_valid = 0; exu_rd = 0; exu_wdata = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_wdata = 0;
  endtask

  task automatic apply_reset();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; exu_valid = 1; exu_rd = 1; lsu_valid = 0;
    #1;
    chk_cnt++; if (exu_ready !== 1'b0) $display("FAIL rst_exu_ready got %b want 0", exu_ready); else pass_cnt++;
    chk_cnt++; if (iss_ready !== 1'b0) $display("FAIL rst_iss_ready got %b want 0", iss_ready); else pass_cnt++;
    tick(); tick();
    rst = 0; exu_valid = 0;
    tick();
    chk_cnt++; if (gpr_wen !== 1'b0) $display("FAIL rst_wen got %b want 0", gpr_wen); else pass_cnt++;
    chk_cnt++; if (pend_cnt !== 6'd0) $display("FAIL rst_pend got %0d want 0", pend_cnt); else pass_cnt++;
    chk_cnt++; if (wb_err !== 1'b0) $display("FAIL rst_err got %b want 0", wb_err); else pass_cnt++;
    chk_cnt++; if (gpr_waddr !== 5'd0 || gpr_wdata !== 32'd0)
      $display("FAIL rst_wport got %0d/%h want 0/0", gpr_waddr, gpr_wdata); else pass_cnt++;
    for (int r = 0; r < 32; r += 7) begin
      chk_raddr1 = 5'(r); chk_raddr2 = 5'(31 - r); iss_rd = 5'(r);
      #1;
      chk_cnt++;
      if (chk_busy1 !== 1'b0 || chk_busy2 !== 1'b0 || iss_ready !== 1'b1)
        $display("FAIL rst_idle r=%0d got b1=%b b2=%b rdy=%b want 0 0 1", r, chk_busy1, chk_busy2, iss_ready);
      else pass_cnt++;
    end
    idle_inputs();
  endtask

  task automatic test_issue_write();
    iss_valid = 1; iss_rd = 5; #1;
    chk_cnt++; if (iss_ready !== 1'b1) $display("FAIL iw_iss_ready got %b want 1", iss_ready); else pass_cnt++;
    tick();
    iss_valid = 0; chk_raddr1 = 5; #1;
    chk_cnt++; if (chk_busy1 !== 1'b1 || pend_cnt !== 6'd1)
      $display("FAIL iw_busy got %b/%0d want 1/1", chk_busy1, pend_cnt); else pass_cnt++;
    exu_valid = 1; exu_rd = 5; exu_wdata = 32'hDEADBEEF; #1;
    chk_cnt++; if (exu_ready !== 1'b1) $display("FAIL iw_exu_ready got %b want 1", exu_ready); else pass_cnt++;
    exp_q.push_back('{addr: 5'd5, data: 32'hDEADBEEF});
    tick();
    exu_valid = 0; #1;
    chk_cnt++; if (gpr_wen !== 1'b1 || chk_busy1 !== 1'b1 || pend_cnt !== 6'd1)
      $display("FAIL iw_wcycle got wen=%b busy=%b pend=%0d want 1 1 1", gpr_wen, chk_busy1, pend_cnt); else pass_cnt++;
    tick();
    chk_cnt++; if (gpr_wen !== 1'b0 || chk_busy1 !== 1'b0 || pend_cnt !== 6'd0)
      $display("FAIL iw_retire got wen=%b busy=%b pend=%0d want 0 0 0", gpr_wen, chk_busy1, pend_cnt); else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_round_robin();
    apply_reset();
    iss_valid = 1; iss_rd = 3; tick();
    iss_rd = 4; tick();
    iss_valid = 0; iss_rd = 0;
    exu_valid = 1; exu_rd = 3; exu_wdata = 32'hAAAA0003;
    lsu_valid = 1; lsu_rd = 4; lsu_wdata = 32'h55550004;
    #1;
    chk_cnt++; if (exu_ready !== 1'b1 || lsu_ready !== 1'b0)
      $display("FAIL rr_c1 got exu=%b lsu=%b want 1 0", exu_ready, lsu_ready); else pass_cnt++;
    exp_q.push_back('{addr: 5'd3, data: 32'hAAAA0003});
    tick();
    exu_rd = 0; exu_wdata = 32'h0BAD0BAD; #1;
    chk_cnt++; if (exu_ready !== 1'b0 || lsu_ready !== 1'b1)
      $display("FAIL rr_c2 got exu=%b lsu=%b want 0 1", exu_ready, lsu_ready); else pass_cnt++;
    exp_q.push_back('{addr: 5'd4, data: 32'h55550004});
    tick();
    lsu_valid = 0; #1;
    chk_cnt++; if (exu_ready !== 1'b1 || gpr_waddr !== 5'd4)
      $display("FAIL rr_c3 got exu=%b waddr=%0d want 1 4", exu_ready, gpr_waddr); else pass_cnt++;
    tick();
    exu_valid = 0;
    tick();
    chk_cnt++; if (pend_cnt !== 6'd0 || gpr_wen !== 1'b0)
      $display("FAIL rr_end got pend=%0d wen=%b want 0 0", pend_cnt, gpr_wen); else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_busy_retry();
    iss_valid = 1; iss_rd = 7; tick();
    chk_raddr2 = 7; #1;
    chk_cnt++; if (iss_ready !== 1'b0 || chk_busy2 !== 1'b1)
      $display("FAIL br_refuse got rdy=%b busy=%b want 0 1", iss_ready, chk_busy2); else pass_cnt++;
    exu_valid = 1; exu_rd = 7; exu_wdata = 32'h00000777; #1;
    exp_q.push_back('{addr: 5'd7, data: 32'h00000777});
    tick();
    exu_valid = 0; #1;
    chk_cnt++; if (gpr_wen !== 1'b1 || iss_ready !== 1'b0)
      $display("FAIL br_nobypass got wen=%b rdy=%b want 1 0", gpr_wen, iss_ready); else pass_cnt++;
    tick();
    chk_cnt++; if (iss_ready !== 1'b1 || pend_cnt !== 6'd0)
      $display("FAIL br_retry got rdy=%b pend=%0d want 1 0", iss_ready, pend_cnt); else pass_cnt++;
    tick();
    iss_rd = 0; #1;
    chk_cnt++; if (chk_busy2 !== 1'b1 || pend_cnt !== 6'd1 || iss_ready !== 1'b1)
      $display("FAIL br_reserved got busy=%b pend=%0d rdy0=%b want 1 1 1", chk_busy2, pend_cnt, iss_ready); else pass_cnt++;
    tick();
    iss_valid = 0; #1;
    chk_cnt++; if (pend_cnt !== 6'd1)
      $display("FAIL br_rd0_pend got %0d want 1", pend_cnt); else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_rd0_write();
    exu_valid = 1; exu_rd = 0; exu_wdata = 32'h00001234; #1;
    chk_cnt++; if (exu_ready !== 1'b1) $display("FAIL rd0_ready got %b want 1", exu_ready); else pass_cnt++;
    tick();
    exu_valid = 0; #1;
    chk_cnt++; if (gpr_wen !== 1'b0 || wb_err !== 1'b0 || pend_cnt !== 6'd1)
      $display("FAIL rd0_nowrite got wen=%b err=%b pend=%0d want 0 0 1", gpr_wen, wb_err, pend_cnt); else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_err_and_reset();
    lsu_valid = 1; lsu_rd = 9; lsu_wdata = 32'h55AA0009; #1;
    chk_cnt++; if (lsu_ready !== 1'b1 || wb_err !== 1'b0)
      $display("FAIL er_grant got rdy=%b err=%b want 1 0", lsu_ready, wb_err); else pass_cnt++;
    exp_q.push_back('{addr: 5'd9, data: 32'h55AA0009});
    tick();
    lsu_valid = 0; #1;
    chk_cnt++; if (wb_err !== 1'b1 || gpr_wen !== 1'b1)
      $display("FAIL er_set got err=%b wen=%b want 1 1", wb_err, gpr_wen); else pass_cnt++;
    tick();
    chk_cnt++; if (wb_err !== 1'b1 || gpr_wen !== 1'b0 || gpr_waddr !== 5'd9 || gpr_wdata !== 32'h55AA0009)
      $display("FAIL er_sticky got err=%b wen=%b addr=%0d data=%h want 1 0 9 55aa0009",
               wb_err, gpr_wen, gpr_waddr, gpr_wdata); else pass_cnt++;
    iss_valid = 1; iss_rd = 10; tick();
    iss_rd = 11; tick();
    iss_valid = 0; chk_raddr1 = 10; chk_raddr2 = 7; #1;
    chk_cnt++; if (pend_cnt !== 6'd3 || chk_busy1 !== 1'b1 || chk_busy2 !== 1'b1)
      $display("FAIL er_pre got pend=%0d b1=%b b2=%b want 3 1 1", pend_cnt, chk_busy1, chk_busy2); else pass_cnt++;
    rst = 1; tick();
    rst = 0; #1;
    chk_cnt++; if (pend_cnt !== 6'd0 || wb_err !== 1'b0 || chk_busy1 !== 1'b0 || chk_busy2 !== 1'b0 || gpr_wen !== 1'b0)
      $display("FAIL er_reset got pend=%0d err=%b b1=%b b2=%b wen=%b want 0 0 0 0 0",
               pend_cnt, wb_err, chk_busy1, chk_busy2, gpr_wen); else pass_cnt++;
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_issue_write();
    test_round_robin();
    test_busy_retry();
    test_rd0_write();
    test_err_and_reset();
    tick(); tick();
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL sb_drain got %0d pending writes want 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
- Owns the single write port of the GPR file and shares it between two writeback requesters: EXU results (req 0) and LSU load data (req 1). Arbitration is round-robin.
- Also holds a per-register pending-write scoreboard. Issue logic marks a destination busy; decode checks source operands against it for RAW hazards.
- Sits between EXU/LSU and the GPR file; its outputs connect directly to the GPR write-enable, write-address and write-data inputs.

Parameters:
- GPR_ADDR_WIDTH, 5, GPR index width; the block tracks 2**GPR_ADDR_WIDTH registers.
- DATA_WIDTH, 32, writeback data width.

Ports:
- wbarb_clk  in  1  clock, rising edge.
- wbarb_rst  in  1  reset, synchronous, active-high.
- iss_valid  in  1  issue wants to reserve a destination.
- iss_rd  in  GPR_ADDR_WIDTH  destination to reserve.
- iss_ready  out  1  reservation accepted this cycle.
- chk_raddr1  in  GPR_ADDR_WIDTH  source 1 to check.
- chk_raddr2  in  GPR_ADDR_WIDTH  source 2 to check.
- chk_busy1  out  1  source 1 has a pending write.
- chk_busy2  out  1  source 2 has a pending write.
- exu_valid  in  1  EXU writeback request.
- exu_rd  in  GPR_ADDR_WIDTH  EXU destination.
- exu_wdata  in  DATA_WIDTH  EXU result.
- exu_ready  out  1  EXU request granted.
- lsu_valid  in  1  LSU writeback request.
- lsu_rd  in  GPR_ADDR_WIDTH  LSU destination.
- lsu_wdata  in  DATA_WIDTH  LSU load data.
- lsu_ready  out  1  LSU request granted.
- gpr_wen  out  1  GPR write enable, registered.
- gpr_waddr  out  GPR_ADDR_WIDTH  GPR write address, registered.
- gpr_wdata  out  DATA_WIDTH  GPR write data, registered.
- pend_cnt  out  GPR_ADDR_WIDTH+1  number of busy registers.
- wb_err  out  1  sticky error: writeback to a non-busy register.

Behaviour:
- Interface: one clock, wbarb_clk. Reset wbarb_rst is synchronous and active-high.
- Reset values:
  - busy[] all 0; pend_cnt 0; wb_err 0.
  - gpr_wen 0, gpr_waddr 0, gpr_wdata 0.
  - Round-robin pointer favours EXU.
  - While wbarb_rst is high: iss_ready, exu_ready and lsu_ready are 0.
  - Reset mid-operation discards all reservations and any request in flight; no write is emitted in the cycle after reset.
- Handshake (valid/ready): a transfer occurs when valid and ready are both high at a rising edge.
  - ready may depend combinationally on valid. valid must not depend on ready.
  - Requesters hold rd/wdata stable while valid is high and not yet accepted.
- Arbitration (combinational):
  - Only one requester valid: it is granted.
  - Both valid: grant the requester the pointer favours.
  - After any grant, the pointer moves to favour the other requester.
  - At most one of exu_ready/lsu_ready is high in a cycle.
- Write port:
  - A granted request is registered: gpr_wen=1, gpr_waddr=rd, gpr_wdata=data on the next cycle. Latency is exactly 1; no stall, since the GPR always accepts.
  - rd=0 is accepted (ready=1) but gpr_wen stays 0 and the scoreboard is unaffected.
  - With no grant, gpr_wen=0 next cycle; gpr_waddr and gpr_wdata hold their last values.
- Scoreboard:
  - iss_ready = !rst && (iss_rd==0 || !busy[iss_rd]).
  - Accepted issue with iss_rd!=0 sets busy[iss_rd] at the edge. rd=0 is accepted and never marked.
  - busy[r] clears at the edge that ends a cycle with gpr_wen=1 and gpr_waddr=r, i.e. the same edge at which the GPR captures the data. The register therefore reads busy until its value is architecturally visible.
  - iss_ready uses current busy with no same-cycle bypass. Issue to a register whose clear happens this cycle is refused and retried the next cycle.
  - Set of register X and clear of register Y in the same cycle both take effect. X==Y in the same cycle cannot occur because of the iss_ready rule.
  - chk_busyN = busy[chk_raddrN], forced to 0 for address 0. Purely combinational.
  - pend_cnt = popcount(busy): +1 on set, -1 on clear, unchanged when both occur. Range 0..2**GPR_ADDR_WIDTH-1.
- wb_err is set when a grant occurs with rd!=0 and busy[rd]==0. It is sticky until reset. The write is still performed.

Test Plan:
- Reset then idle: gpr_wen=0, pend_cnt=0, chk_busy1/2=0, iss_ready=1 for any rd. During the rst cycle, exu_valid=1 gives exu_ready=0.
- Issue rd=5, then EXU writes rd=5, data 0xDEADBEEF: chk_busy1(5)=1 from the cycle after issue. Grant, then next cycle gpr_wen=1, waddr=5, wdata=0xDEADBEEF. busy[5]=0 the cycle after; pend_cnt goes 1 then 0.
- Issue rd 3 and rd 4; both requesters valid for 2 cycles (EXU rd=3, LSU rd=4): cycle 1 grants EXU, cycle 2 grants LSU. Writes appear in order 3, then 4.
- Issue rd=7 while busy[7]=1: iss_ready=0. Retry in the cycle after the write to 7 retires: accepted. Issue rd=0 is always accepted and pend_cnt is unchanged.
- EXU writes rd=0 with data 0x1234: exu_ready=1, gpr_wen stays 0, wb_err stays 0.
- LSU writes rd=9 with no prior issue: write emitted, wb_err=1 and stays 1. Then assert rst mid-stream with 3 busy registers: pend_cnt=0, wb_err=0, all chk_busy=0 next cycle.
